// File: rtl/inst_buf_pkg.sv
// Shared constants, entry type and helpers for the instruction fetch buffer.
package inst_buf_pkg;

  localparam int FETCH_WIDTH  = 4;
  localparam int DECODE_WIDTH = 2;
  localparam int INST_W       = 32;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } ib_entry_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/ib_compact.sv
// Compaction map for one fetch group: each valid slot's write offset from
// tail (the number of valid slots below it), its enable, and the total count.
module ib_compact
  import inst_buf_pkg::*;
(
  input  logic [FETCH_WIDTH-1:0]   group_valid,
  output logic [2*FETCH_WIDTH-1:0] offset,
  output logic [FETCH_WIDTH-1:0]   slot_en,
  output logic [2:0]               n
);

  logic [2:0] acc;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it holding its old value and a latch is never inferred.
  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      offset[2*i +: 2] = acc[1:0];
      acc              = acc + 3'(group_valid[i]);
    end
  end

  assign slot_en = group_valid;
  assign n       = acc;

endmodule

// File: rtl/inst_fetch_buffer.sv
// Circular instruction queue between ICache and decode: 4-wide compacting
// push, 2-wide pop. Define INST_FETCH_BUFFER_PERF_EN to add perf counters.
module inst_fetch_buffer
  import inst_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_group_pc,
  input  logic [127:0] in_group,
  input  logic [3:0]  in_group_valid,
  output logic [1:0]  out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst0,
  output logic [31:0] out_pc0,
  output logic [31:0] out_inst1,
  output logic [31:0] out_pc1
`ifdef INST_FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_empty_cycles
`endif
);

  localparam int CNT_W = PTR_W + 1;

  ib_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [2*FETCH_WIDTH-1:0] offset;
  logic [FETCH_WIDTH-1:0]   slot_en;
  logic [2:0]               n;
  logic [2:0]               m;
  logic                     push;
  logic                     pop;
  ib_entry_t                lane0;
  ib_entry_t                lane1;
  logic                     unused_pc_bits;

  ib_compact u_compact (
    .group_valid (in_group_valid),
    .offset      (offset),
    .slot_en     (slot_en),
    .n           (n)
  );

  // The low address bits are rebuilt from the slot index.
  assign unused_pc_bits = ^in_group_pc[3:0];

  assign in_ready  = (DEPTH - int'(count)) >= FETCH_WIDTH;
  assign out_valid = {count >= CNT_W'(2), count >= CNT_W'(1)};
  assign m         = popcount4({2'b00, out_valid});
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_ready & ~flush;

  // NOTE: the entry array is deliberately left out of reset; out_valid gates
  // its contents, and skipping the reset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (slot_en[i]) begin
          mem[tail + PTR_W'(offset[2*i +: 2])] <= '{
            pc:   {in_group_pc[31:4], 2'(i), 2'b00},
            inst: in_group[INST_W*i +: INST_W]
          };
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(n);
      if (pop)  head <= head + PTR_W'(m);
      count <= count + (push ? CNT_W'(n) : '0) - (pop ? CNT_W'(m) : '0);
    end
  end

  assign lane0     = mem[head];
  assign lane1     = mem[head + PTR_W'(1)];
  assign out_inst0 = lane0.inst;
  assign out_pc0   = lane0.pc;
  assign out_inst1 = lane1.inst;
  assign out_pc1   = lane1.pc;

`ifdef INST_FETCH_BUFFER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (in_valid && !in_ready && perf_full_cycles != '1)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (count == '0 && !flush && perf_empty_cycles != '1)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed vector table, corner
// sequences and random traffic against a queue-based reference model.
module tb_inst_fetch_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_group_pc;
  logic [127:0] in_group;
  logic [3:0]   in_group_valid;
  logic [1:0]   out_valid;
  logic         out_ready;
  logic [31:0]  out_inst0, out_pc0, out_inst1, out_pc1;
`ifdef INST_FETCH_BUFFER_PERF_EN
  logic [31:0]  perf_full_cycles, perf_empty_cycles;
  logic [31:0]  exp_full, exp_empty;
`endif

  inst_fetch_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_group_pc    (in_group_pc),
    .in_group       (in_group),
    .in_group_valid (in_group_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst0      (out_inst0),
    .out_pc0        (out_pc0),
    .out_inst1      (out_inst1),
    .out_pc1        (out_pc1)
`ifdef INST_FETCH_BUFFER_PERF_EN
    ,
    .perf_full_cycles  (perf_full_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  localparam int CAP = 16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_group(input logic [31:0] pc, input logic [3:0] mask, input logic [31:0] base);
    in_group_pc    = pc;
    in_group_valid = mask;
    for (int i = 0; i < 4; i++) in_group[32*i +: 32] = base + 32'(i);
  endtask

  task automatic check_outputs();
    logic [1:0] ev;
    ev = {q.size() >= 2, q.size() >= 1};
    check("out_valid", 64'(out_valid), 64'(ev));
    check("in_ready", 64'(in_ready), 64'(q.size() <= CAP - 4));
    if (q.size() >= 1) begin
      check("inst0", 64'(out_inst0), 64'(q[0].inst));
      check("pc0", 64'(out_pc0), 64'(q[0].pc));
    end
    if (q.size() >= 2) begin
      check("inst1", 64'(out_inst1), 64'(q[1].inst));
      check("pc1", 64'(out_pc1), 64'(q[1].pc));
    end
`ifdef INST_FETCH_BUFFER_PERF_EN
    check("perf_full", 64'(perf_full_cycles), 64'(exp_full));
    check("perf_empty", 64'(perf_empty_cycles), 64'(exp_empty));
`endif
  endtask

  // One clock: decide handshakes from pre-edge model state, advance the
  // model after the edge, then compare.
  task automatic cycle();
    bit   do_push, do_pop;
    ent_t e;
    do_push = in_valid && (q.size() <= CAP - 4) && !flush;
    do_pop  = out_ready && !flush;
`ifdef INST_FETCH_BUFFER_PERF_EN
    if (rst) begin
      exp_full  = 0;
      exp_empty = 0;
    end else begin
      if (in_valid && q.size() > CAP - 4 && exp_full != '1) exp_full++;
      if (q.size() == 0 && !flush && exp_empty != '1) exp_empty++;
    end
`endif
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (do_pop) begin
        for (int k = 0; k < 2; k++) if (q.size() > 0) void'(q.pop_front());
      end
      if (do_push) begin
        for (int i = 0; i < 4; i++) begin
          if (in_group_valid[i]) begin
            e.pc   = {in_group_pc[31:4], 4'(i * 4)};
            e.inst = in_group[32*i +: 32];
            q.push_back(e);
          end
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic push_group(input logic [31:0] pc, input logic [3:0] mask, input logic [31:0] base);
    set_group(pc, mask, base);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [1:0] valid;
    logic [1:0] slot0;
    logic [1:0] slot1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_group(32'h0, 4'h0, 32'h0);

    vecs[0] = '{4'b1111, 2'b11, 2'd0, 2'd1};
    vecs[1] = '{4'b1010, 2'b11, 2'd1, 2'd3};
    vecs[2] = '{4'b0100, 2'b01, 2'd2, 2'd0};
    vecs[3] = '{4'b0000, 2'b00, 2'd0, 2'd0};
    vecs[4] = '{4'b1001, 2'b11, 2'd0, 2'd3};
    vecs[5] = '{4'b0110, 2'b11, 2'd1, 2'd2};

    // Reset state
    do_reset();
    check("reset_valid", 64'(out_valid), 64'(2'b00));
    check("reset_ready", 64'(in_ready), 64'(1'b1));

    // Single-group compaction vectors
    foreach (vecs[v]) begin
      do_reset();
      push_group(32'h1C00_0010, vecs[v].mask, 32'hA000_0000);
      check("vec_valid", 64'(out_valid), 64'(vecs[v].valid));
      if (vecs[v].valid[0]) begin
        check("vec_pc0", 64'(out_pc0), 64'({28'h1C0_0001, vecs[v].slot0, 2'b00}));
        check("vec_inst0", 64'(out_inst0), 64'(32'hA000_0000 + 32'(vecs[v].slot0)));
      end
      if (vecs[v].valid[1]) begin
        check("vec_pc1", 64'(out_pc1), 64'({28'h1C0_0001, vecs[v].slot1, 2'b00}));
        check("vec_inst1", 64'(out_inst1), 64'(32'hA000_0000 + 32'(vecs[v].slot1)));
      end
    end

    // Basic push/pop with out_ready held
    do_reset();
    out_ready = 1'b1;
    push_group(32'h1C00_0000, 4'b1111, 32'h0000_00A0);
    check("basic_pc0", 64'(out_pc0), 64'(32'h1C00_0000));
    check("basic_pc1", 64'(out_pc1), 64'(32'h1C00_0004));
    check("basic_inst0", 64'(out_inst0), 64'(32'h0000_00A0));
    cycle();
    check("basic_pc0b", 64'(out_pc0), 64'(32'h1C00_0008));
    check("basic_inst1b", 64'(out_inst1), 64'(32'h0000_00A3));
    cycle();
    check("basic_empty", 64'(out_valid), 64'(2'b00));

    // Full boundary
    do_reset();
    for (int g = 0; g < 4; g++) push_group(32'h2000_0000 + 32'(g * 16), 4'b1111, 32'(g * 4));
    check("full_ready", 64'(in_ready), 64'(1'b0));
    push_group(32'h2000_0100, 4'b1111, 32'hDEAD_0000);
    check("full_hold", 64'(q.size()), 64'(16));
    out_ready = 1'b1;
    cycle();
    check("full_14", 64'(in_ready), 64'(1'b0));
    cycle();
    check("full_12", 64'(in_ready), 64'(1'b1));
    out_ready = 1'b0;

    // count = DEPTH-3 with a same-cycle pop still refuses the group
    do_reset();
    for (int g = 0; g < 3; g++) push_group(32'h3000_0000 + 32'(g * 16), 4'b1111, 32'(g * 4));
    push_group(32'h3000_0030, 4'b0001, 32'h0000_0030);
    check("ready_at_13", 64'(in_ready), 64'(1'b0));
    out_ready = 1'b1;
    push_group(32'h3000_0040, 4'b1111, 32'hBAD0_0000);
    check("no_push_at_13", 64'(q.size()), 64'(11));
    out_ready = 1'b0;

    // Wrap: tail reaches 14, then a 4-wide group spans 14,15,0,1
    do_reset();
    for (int g = 0; g < 3; g++) push_group(32'h4000_0000 + 32'(g * 16), 4'b1111, 32'(g * 4));
    push_group(32'h4000_0030, 4'b0011, 32'h0000_0030);
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) cycle();
    out_ready = 1'b0;
    push_group(32'h4000_0040, 4'b1111, 32'h0000_0E00);
    check("wrap_pc0", 64'(out_pc0), 64'(32'h4000_0040));
    out_ready = 1'b1;
    cycle();
    check("wrap_pc0b", 64'(out_pc0), 64'(32'h4000_0048));
    check("wrap_inst1b", 64'(out_inst1), 64'(32'h0000_0E03));
    cycle();
    out_ready = 1'b0;

    // Flush during push and pop
    do_reset();
    push_group(32'h5000_0000, 4'b1111, 32'h0);
    push_group(32'h5000_0010, 4'b0011, 32'h10);
    set_group(32'h5000_0020, 4'b1111, 32'hF1F1_0000);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_valid", 64'(out_valid), 64'(2'b00));
    check("flush_ready", 64'(in_ready), 64'(1'b1));
    push_group(32'h5000_0040, 4'b0001, 32'h0000_0777);
    check("flush_newer", 64'(out_inst0), 64'(32'h0000_0777));

    // Reset mid-operation overrides flush and push
    for (int g = 0; g < 2; g++) push_group(32'h6000_0000 + 32'(g * 16), 4'b1111, 32'(g * 4));
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    cycle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rst_valid", 64'(out_valid), 64'(2'b00));
    check("rst_ready", 64'(in_ready), 64'(1'b1));
`ifdef INST_FETCH_BUFFER_PERF_EN
    check("rst_perf_full", 64'(perf_full_cycles), 64'(0));
    check("rst_perf_empty", 64'(perf_empty_cycles), 64'(0));
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      set_group($urandom, 4'($urandom), $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 300) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
